jump_redirect_ctrl: RTL and testbench
=====================================

# jump_redirect_ctrl

Execute-stage control-transfer sequencer for the RV32I pipeline. It takes the decoded JAL, JALR and conditional-branch controls plus the sign-extended, pre-shifted immediate offsets from the execute-stage immediate generators. It then:
- computes and registers the target;
- drives a ready/valid PC redirect to fetch;
- holds execute until fetch accepts the redirect;
- squashes the wrong-path instructions already in IF/ID for a programmable number of cycles;
- produces the link value for JAL/JALR;
- flags misaligned targets instead of redirecting.

## Interface
Parameters:
- FLUSH_CYCLES, 2, cycles of `kill_id` after redirect acceptance (1..7)
- XLEN, 32, datapath width

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX holds a valid instruction this cycle
- ex_is_jal  in  1  instruction is JAL
- ex_is_jalr  in  1  instruction is JALR
- ex_is_branch  in  1  instruction is a conditional branch
- branch_taken  in  1  branch comparator result (ignored unless ex_is_branch)
- ex_pc  in  XLEN  PC of the EX instruction
- pc_offset  in  XLEN  sign-extended, shifted J/B-type offset
- jalr_base  in  XLEN  rs1 value
- jalr_imm  in  XLEN  sign-extended I-type immediate
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  XLEN  new fetch PC
- redirect_ready  in  1  fetch accepts the redirect
- ex_hold  out  1  freeze the EX stage and the stages before it
- kill_id  out  1  squash the instruction in IF/ID
- link_we  out  1  one-cycle write of the link value to rd
- link_data  out  XLEN  ex_pc + 4
- misalign_trap  out  1  one-cycle instruction-address-misaligned pulse
- trap_pc  out  XLEN  faulting target address
- redirect_count  out  32  number of redirects accepted, wraps

## Operation
- A control transfer (`take`) is: `ex_valid & ~ex_hold & (ex_is_jal | ex_is_jalr | (ex_is_branch & branch_taken))`.
- Target calculation:
  - JAL and taken branches: `ex_pc + pc_offset`, modulo 2^32.
  - JALR: `(jalr_base + jalr_imm) & ~1`.
  - If more than one type flag is set, priority is jalr > jal > branch.
- Misaligned target (bit 1 set, no compressed ISA):
  - pulse `misalign_trap` with `trap_pc` = target;
  - no redirect, no link write;
  - the FSM stays in IDLE.
- Link write: JAL/JALR with an aligned target pulses `link_we` with `link_data = ex_pc + 4` in the take cycle. Both outputs are combinational from the EX inputs.
- A not-taken branch, or `ex_valid` = 0, produces no response.
- FSM states: IDLE, REDIR, FLUSH.
  - IDLE -> REDIR on an aligned `take`; the target is registered into `redirect_pc`.
  - REDIR: `redirect_valid` = 1 and `ex_hold` = 1. `redirect_pc` stays stable until the handshake.
  - REDIR -> FLUSH on `redirect_valid & redirect_ready`. The counter loads FLUSH_CYCLES and `redirect_count` increments.
  - FLUSH: `kill_id` = 1 and `ex_hold` = 0. The counter decrements each cycle; FLUSH -> IDLE when it reaches 1.
  - A `take` is accepted only in IDLE. In FLUSH the EX instruction is wrong-path, so `take` is masked and EX inputs are ignored.
- Reset, asynchronous and possible at any state: state = IDLE, counter = 0, `redirect_pc` = 0, `redirect_count` = 0. All outputs read 0, except `link_data` and `trap_pc`, which are combinational from the inputs.

## Timing
- Take in cycle t -> `redirect_valid` first high in cycle t+1. The earliest acceptance is t+1.
- Accepted at the edge ending cycle a -> `kill_id` is high for cycles a+1 .. a+FLUSH_CYCLES. IDLE in cycle a+FLUSH_CYCLES+1.
- Minimum spacing between redirects is 2+FLUSH_CYCLES cycles.
- `ex_hold` is combinational: (state == REDIR).
- `link_we` and `misalign_trap` are combinational and take effect in cycle t. They never assert outside IDLE.
- `redirect_count` updates on the acceptance edge and wraps from 0xFFFFFFFF to 0.

## Structure
- Shared package `riscv_ctrl_pkg`:
  - FSM state enum;
  - `PC_STEP` (4);
  - `ALIGN_MASK_JALR` (~1);
  - flush-width localparam derived from FLUSH_CYCLES.
- One sub-module: `jump_target_calc`, combinational. It produces the target, the misaligned flag and the link value from the type flags, PC, offsets and base.
- The top level holds the FSM, the flush counter, the target register and the statistics counter.

## Test plan
- JAL, `ex_pc`=0x100, `pc_offset`=0x20, `redirect_ready`=1 -> `link_we`/`link_data`=0x104 in t; `redirect_pc`=0x120 valid in t+1; `kill_id` for 2 cycles; `redirect_count`=1.
- Taken branch, `ex_pc`=0x100, `pc_offset`=0xFFFFFFF0 -> `redirect_pc`=0xF0, `link_we`=0. The same branch not taken -> no output activity.
- JALR, base=0x2001, imm=4 -> `redirect_pc`=0x2004. JALR, base=0x2000, imm=2 -> `misalign_trap` pulse, `trap_pc`=0x2002, no redirect, state stays IDLE.
- `redirect_ready` low for 3 cycles -> `redirect_valid` and `ex_hold` held 3 cycles with `redirect_pc` unchanged. A second JAL presented meanwhile is ignored.
- `rst_n` asserted mid-FLUSH -> `kill_id`, `ex_hold` and `redirect_valid` go 0 immediately; a JAL after release redirects normally. With `redirect_count` preloaded to 0xFFFFFFFF, one more accepted redirect wraps it to 0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared control-transfer definitions for the RV32I execute stage:
// FSM states, PC step, JALR alignment mask and flush-counter sizing.
package riscv_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REDIR = 2'd1,
        ST_FLUSH = 2'd2
    } ctrl_state_e;

    localparam logic [31:0] PC_STEP         = 32'd4;
    localparam logic [31:0] ALIGN_MASK_JALR = ~32'd1;

    localparam int FLUSH_CYCLES_MAX = 7;

    // Counter must hold FLUSH_CYCLES itself, so size for value+1 states.
    function automatic int flush_cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

    localparam int FLUSH_CNT_W_MAX = flush_cnt_width(FLUSH_CYCLES_MAX);

endpackage

// File: rtl/jump_redirect_ctrl_if.sv
// PC redirect channel from execute to fetch. redirect_pc is stable while
// redirect_valid is high; transfer happens on redirect_valid & redirect_ready.
interface jump_redirect_ctrl_if #(
    parameter int XLEN = 32
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;

    modport master (
        output redirect_valid,
        output redirect_pc,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ready
    );
endinterface

// File: rtl/jump_target_calc.sv
// Combinational target/link generator for JAL, JALR and conditional branches.
module jump_target_calc
    import riscv_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            is_jalr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_offset,
    input  logic [XLEN-1:0] jalr_base,
    input  logic [XLEN-1:0] jalr_imm,
    output logic [XLEN-1:0] target,
    output logic            misaligned,
    output logic [XLEN-1:0] link
);

    always_comb begin
        target = pc + pc_offset;
        if (is_jalr) begin
            target = (jalr_base + jalr_imm) & XLEN'(ALIGN_MASK_JALR);
        end
        // No compressed ISA: any target with bit 1 set is misaligned.
        misaligned = target[1];
        link       = pc + XLEN'(PC_STEP);
    end

endmodule

// File: rtl/jump_redirect_ctrl.sv
// Execute-stage control-transfer sequencer: registers the target, issues the
// redirect, holds EX until accepted, then squashes IF/ID for FLUSH_CYCLES.
module jump_redirect_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int XLEN         = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_valid,
    input  logic                ex_is_jal,
    input  logic                ex_is_jalr,
    input  logic                ex_is_branch,
    input  logic                branch_taken,
    input  logic [XLEN-1:0]     ex_pc,
    input  logic [XLEN-1:0]     pc_offset,
    input  logic [XLEN-1:0]     jalr_base,
    input  logic [XLEN-1:0]     jalr_imm,
    jump_redirect_ctrl_if.master redir,
    output logic                ex_hold,
    output logic                kill_id,
    output logic                link_we,
    output logic [XLEN-1:0]     link_data,
    output logic                misalign_trap,
    output logic [XLEN-1:0]     trap_pc,
    output logic [31:0]         redirect_count,
    output ctrl_state_e         dbg_state
);

    localparam int CNT_W = flush_cnt_width(FLUSH_CYCLES);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic [31:0]      redirect_count_q, redirect_count_d;

    logic [XLEN-1:0]  target;
    logic             misaligned;
    logic             is_xfer;
    logic             take;
    logic             take_ok;

    jump_target_calc #(.XLEN(XLEN)) u_calc (
        .is_jalr    (ex_is_jalr),
        .pc         (ex_pc),
        .pc_offset  (pc_offset),
        .jalr_base  (jalr_base),
        .jalr_imm   (jalr_imm),
        .target     (target),
        .misaligned (misaligned),
        .link       (link_data)
    );

    // EX inputs are wrong-path during FLUSH, so takes are honoured in IDLE only.
    assign is_xfer = ex_is_jal | ex_is_jalr | (ex_is_branch & branch_taken);
    assign take    = ex_valid & ~ex_hold & is_xfer & (state_q == ST_IDLE);
    assign take_ok = take & ~misaligned;

    assign ex_hold        = (state_q == ST_REDIR);
    assign kill_id        = (state_q == ST_FLUSH);
    assign link_we        = take_ok & (ex_is_jal | ex_is_jalr);
    assign misalign_trap  = take & misaligned;
    assign trap_pc        = target;
    assign redir.redirect_valid = (state_q == ST_REDIR);
    assign redir.redirect_pc    = redirect_pc_q;
    assign redirect_count = redirect_count_q;
    assign dbg_state      = state_q;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        redirect_pc_d    = redirect_pc_q;
        redirect_count_d = redirect_count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (take_ok) begin
                    state_d       = ST_REDIR;
                    redirect_pc_d = target;
                end
            end
            ST_REDIR: begin
                if (redir.redirect_ready) begin
                    state_d          = ST_FLUSH;
                    cnt_d            = CNT_W'(FLUSH_CYCLES);
                    redirect_count_d = redirect_count_q + 32'd1;
                end
            end
            ST_FLUSH: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            redirect_pc_q    <= '0;
            redirect_count_q <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            redirect_pc_q    <= redirect_pc_d;
            redirect_count_q <= redirect_count_d;
        end
    end

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// Directed bench for jump_redirect_ctrl: JAL/JALR/branch redirects,
// misalignment, backpressure, reset during flush and counter wrap.
module tb_jump_redirect_ctrl;
    import riscv_ctrl_pkg::*;

    localparam int FC = 2;

    logic        clk;
    logic        rst_n;
    logic        ex_valid, ex_is_jal, ex_is_jalr, ex_is_branch, branch_taken;
    logic [31:0] ex_pc, pc_offset, jalr_base, jalr_imm;
    logic        ex_hold, kill_id, link_we, misalign_trap;
    logic [31:0] link_data, trap_pc, redirect_count;
    ctrl_state_e dbg_state;

    int chk_cnt;
    int pass_cnt;

    jump_redirect_ctrl_if #(.XLEN(32)) rif ();

    jump_redirect_ctrl #(.FLUSH_CYCLES(FC), .XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_is_jal      (ex_is_jal),
        .ex_is_jalr     (ex_is_jalr),
        .ex_is_branch   (ex_is_branch),
        .branch_taken   (branch_taken),
        .ex_pc          (ex_pc),
        .pc_offset      (pc_offset),
        .jalr_base      (jalr_base),
        .jalr_imm       (jalr_imm),
        .redir          (rif),
        .ex_hold        (ex_hold),
        .kill_id        (kill_id),
        .link_we        (link_we),
        .link_data      (link_data),
        .misalign_trap  (misalign_trap),
        .trap_pc        (trap_pc),
        .redirect_count (redirect_count),
        .dbg_state      (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid     = 1'b0;
        ex_is_jal    = 1'b0;
        ex_is_jalr   = 1'b0;
        ex_is_branch = 1'b0;
        branch_taken = 1'b0;
        ex_pc        = '0;
        pc_offset    = '0;
        jalr_base    = '0;
        jalr_imm     = '0;
    endtask

    task automatic drive_jal(input logic [31:0] pc, input logic [31:0] off);
        idle_inputs();
        ex_valid  = 1'b1;
        ex_is_jal = 1'b1;
        ex_pc     = pc;
        pc_offset = off;
    endtask

    task automatic drive_branch(input logic [31:0] pc, input logic [31:0] off, input logic tk);
        idle_inputs();
        ex_valid     = 1'b1;
        ex_is_branch = 1'b1;
        branch_taken = tk;
        ex_pc        = pc;
        pc_offset    = off;
    endtask

    task automatic drive_jalr(input logic [31:0] pc, input logic [31:0] base, input logic [31:0] imm);
        idle_inputs();
        ex_valid   = 1'b1;
        ex_is_jalr = 1'b1;
        ex_pc      = pc;
        jalr_base  = base;
        jalr_imm   = imm;
    endtask

    // scenarios
    task automatic test_reset();
        rst_n = 1'b1;
        idle_inputs();
        rif.redirect_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++; if ({rif.redirect_valid, ex_hold, kill_id, link_we, misalign_trap} !== 5'b0)
            $display("FAIL reset_ctl got=%b exp=00000", {rif.redirect_valid, ex_hold, kill_id, link_we, misalign_trap});
        else pass_cnt++;
        chk_cnt++; if (rif.redirect_pc !== 32'h0 || redirect_count !== 32'h0)
            $display("FAIL reset_regs got pc=%h cnt=%h exp 0/0", rif.redirect_pc, redirect_count);
        else pass_cnt++;
        chk_cnt++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE);
        else pass_cnt++;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_jal();
        rif.redirect_ready = 1'b1;
        drive_jal(32'h100, 32'h20);
        #1;
        chk_cnt++; if (link_we !== 1'b1 || link_data !== 32'h104)
            $display("FAIL jal_link got we=%b data=%h exp 1/00000104", link_we, link_data);
        else pass_cnt++;
        chk_cnt++; if (rif.redirect_valid !== 1'b0) $display("FAIL jal_valid_t got=%b exp=0", rif.redirect_valid);
        else pass_cnt++;
        step();
        idle_inputs();
        #1;
        chk_cnt++; if (rif.redirect_valid !== 1'b1 || rif.redirect_pc !== 32'h120 || ex_hold !== 1'b1)
            $display("FAIL jal_redir got v=%b pc=%h hold=%b exp 1/00000120/1", rif.redirect_valid, rif.redirect_pc, ex_hold);
        else pass_cnt++;
        step();
        // a JAL shown during FLUSH is wrong-path and must not link
        drive_jal(32'h800, 32'h40);
        #1;
        chk_cnt++; if (kill_id !== 1'b1 || ex_hold !== 1'b0 || link_we !== 1'b0 || redirect_count !== 32'd1)
            $display("FAIL jal_flush1 got kill=%b hold=%b we=%b cnt=%0d exp 1/0/0/1", kill_id, ex_hold, link_we, redirect_count);
        else pass_cnt++;
        step();
        idle_inputs();
        #1;
        chk_cnt++; if (kill_id !== 1'b1) $display("FAIL jal_flush2 got=%b exp=1", kill_id);
        else pass_cnt++;
        step();
        chk_cnt++; if (kill_id !== 1'b0 || dbg_state !== ST_IDLE || rif.redirect_valid !== 1'b0)
            $display("FAIL jal_idle got kill=%b st=%0d v=%b exp 0/0/0", kill_id, dbg_state, rif.redirect_valid);
        else pass_cnt++;
    endtask

    task automatic test_branch();
        drive_branch(32'h100, 32'hFFFF_FFF0, 1'b1);
        #1;
        chk_cnt++; if (link_we !== 1'b0 || misalign_trap !== 1'b0)
            $display("FAIL br_link got we=%b trap=%b exp 0/0", link_we, misalign_trap);
        else pass_cnt++;
        step();
        idle_inputs();
        #1;
        chk_cnt++; if (rif.redirect_valid !== 1'b1 || rif.redirect_pc !== 32'hF0)
            $display("FAIL br_redir got v=%b pc=%h exp 1/000000f0", rif.redirect_valid, rif.redirect_pc);
        else pass_cnt++;
        repeat (FC + 1) step();
        drive_branch(32'h100, 32'hFFFF_FFF0, 1'b0);
        #1;
        chk_cnt++; if (link_we !== 1'b0 || misalign_trap !== 1'b0)
            $display("FAIL br_nt_comb got we=%b trap=%b exp 0/0", link_we, misalign_trap);
        else pass_cnt++;
        step();
        idle_inputs();
        #1;
        chk_cnt++; if (rif.redirect_valid !== 1'b0 || dbg_state !== ST_IDLE || redirect_count !== 32'd2)
            $display("FAIL br_nt got v=%b st=%0d cnt=%0d exp 0/0/2", rif.redirect_valid, dbg_state, redirect_count);
        else pass_cnt++;
    endtask

    task automatic test_jalr();
        drive_jalr(32'h300, 32'h2001, 32'h4);
        #1;
        chk_cnt++; if (link_we !== 1'b1 || link_data !== 32'h304)
            $display("FAIL jalr_link got we=%b data=%h exp 1/00000304", link_we, link_data);
        else pass_cnt++;
        step();
        idle_inputs();
        #1;
        chk_cnt++; if (rif.redirect_valid !== 1'b1 || rif.redirect_pc !== 32'h2004)
            $display("FAIL jalr_redir got v=%b pc=%h exp 1/00002004", rif.redirect_valid, rif.redirect_pc);
        else pass_cnt++;
        repeat (FC + 1) step();
        drive_jalr(32'h300, 32'h2000, 32'h2);
        #1;
        chk_cnt++; if (misalign_trap !== 1'b1 || trap_pc !== 32'h2002 || link_we !== 1'b0)
            $display("FAIL jalr_mis got trap=%b tpc=%h we=%b exp 1/00002002/0", misalign_trap, trap_pc, link_we);
        else pass_cnt++;
        step();
        idle_inputs();
        #1;
        chk_cnt++; if (rif.redirect_valid !== 1'b0 || dbg_state !== ST_IDLE || misalign_trap !== 1'b0)
            $display("FAIL jalr_mis_idle got v=%b st=%0d trap=%b exp 0/0/0", rif.redirect_valid, dbg_state, misalign_trap);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        rif.redirect_ready = 1'b0;
        drive_jal(32'h400, 32'h40);
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) drive_jal(32'h500, 32'h10);
            #1;
            chk_cnt++; if (rif.redirect_valid !== 1'b1 || ex_hold !== 1'b1 || rif.redirect_pc !== 32'h440 || link_we !== 1'b0)
                $display("FAIL bp_hold%0d got v=%b hold=%b pc=%h we=%b exp 1/1/00000440/0", i, rif.redirect_valid, ex_hold, rif.redirect_pc, link_we);
            else pass_cnt++;
            step();
            idle_inputs();
        end
        rif.redirect_ready = 1'b1;
        #1;
        chk_cnt++; if (rif.redirect_valid !== 1'b1 || rif.redirect_pc !== 32'h440)
            $display("FAIL bp_accept got v=%b pc=%h exp 1/00000440", rif.redirect_valid, rif.redirect_pc);
        else pass_cnt++;
        step();
        chk_cnt++; if (kill_id !== 1'b1 || redirect_count !== 32'd4)
            $display("FAIL bp_flush got kill=%b cnt=%0d exp 1/4", kill_id, redirect_count);
        else pass_cnt++;
        repeat (FC) step();
    endtask

    task automatic test_reset_mid_flush();
        drive_jal(32'h600, 32'h8);
        step();
        idle_inputs();
        step();
        chk_cnt++; if (kill_id !== 1'b1) $display("FAIL rst_pre got kill=%b exp=1", kill_id);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if ({kill_id, ex_hold, rif.redirect_valid} !== 3'b0 || redirect_count !== 32'd0 || rif.redirect_pc !== 32'd0)
            $display("FAIL rst_mid got ctl=%b cnt=%0d pc=%h exp 000/0/0", {kill_id, ex_hold, rif.redirect_valid}, redirect_count, rif.redirect_pc);
        else pass_cnt++;
        step();
        rst_n = 1'b1;
        step();
        drive_jal(32'h700, 32'h10);
        #1;
        chk_cnt++; if (link_we !== 1'b1 || link_data !== 32'h704)
            $display("FAIL rst_jal_link got we=%b data=%h exp 1/00000704", link_we, link_data);
        else pass_cnt++;
        step();
        idle_inputs();
        #1;
        chk_cnt++; if (rif.redirect_valid !== 1'b1 || rif.redirect_pc !== 32'h710)
            $display("FAIL rst_jal_redir got v=%b pc=%h exp 1/00000710", rif.redirect_valid, rif.redirect_pc);
        else pass_cnt++;
        step();
        chk_cnt++; if (redirect_count !== 32'd1) $display("FAIL rst_jal_cnt got=%0d exp=1", redirect_count);
        else pass_cnt++;
        repeat (FC) step();
    endtask

    task automatic test_count_wrap();
        force dut.redirect_count_q = 32'hFFFF_FFFF;
        repeat (2) step();
        release dut.redirect_count_q;
        #1;
        chk_cnt++; if (redirect_count !== 32'hFFFF_FFFF) $display("FAIL wrap_pre got=%h exp=ffffffff", redirect_count);
        else pass_cnt++;
        drive_jal(32'h900, 32'h100);
        step();
        idle_inputs();
        step();
        chk_cnt++; if (redirect_count !== 32'h0 || kill_id !== 1'b1)
            $display("FAIL wrap got cnt=%h kill=%b exp 00000000/1", redirect_count, kill_id);
        else pass_cnt++;
        repeat (FC) step();
        chk_cnt++; if (dbg_state !== ST_IDLE) $display("FAIL wrap_idle got=%0d exp=0", dbg_state);
        else pass_cnt++;
    endtask

    // sequence and final report
    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        test_reset();
        test_jal();
        test_branch();
        test_jalr();
        test_backpressure();
        test_reset_mid_flush();
        test_count_wrap();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
